// File: rtl/mem_pkg.sv
// Shared encodings and lane geometry helpers for the memory stage.
package mem_pkg;

  // Access size encoding on size_in; 2'b11 is handled as a word
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Handshake FSM states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Number of byte lanes in a data word
  function automatic int lanes_of(input int data_w);
    return data_w / 8;
  endfunction

  // Address bits that select a byte lane (at least one, so slices stay legal)
  function automatic int lane_bits_of(input int data_w);
    int bits;
    bits = 0;
    while ((1 << bits) < (data_w / 8)) bits++;
    return (bits < 1) ? 1 : bits;
  endfunction

  // Geometry of the default 32-bit configuration
  localparam int DATA_W_DEF    = 32;
  localparam int LANES_DEF     = lanes_of(DATA_W_DEF);
  localparam int LANE_BITS_DEF = lane_bits_of(DATA_W_DEF);

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables, store replication, load extract/extend.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int LANE_BITS = 2
) (
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [LANE_BITS-1:0] lane,
  input  logic [DATA_W-1:0]    store_data,
  input  logic [DATA_W-1:0]    rdata,
  output logic [DATA_W/8-1:0]  be,
  output logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    load_value
);

  localparam int LANES    = DATA_W / 8;
  localparam int HALF_MSB = (DATA_W >= 16) ? 15 : DATA_W - 1;

  logic [DATA_W-1:0] shifted;
  logic              sign_bit;

  // Lane decode, store replication and load extraction, all per access size
  always_comb begin
    be         = '0;
    wdata      = '0;
    load_value = '0;
    shifted    = rdata >> {lane, 3'b000};
    sign_bit   = 1'b0;

    case (size)
      SZ_BYTE: be = LANES'(1) << lane;
      SZ_HALF: be = LANES'(3) << lane;
      default: be = '1;
    endcase

    // Replicate so the addressed lane sees the right bytes whatever its offset
    for (int i = 0; i < LANES; i++) begin
      case (size)
        SZ_BYTE: wdata[8*i +: 8] = store_data[7:0];
        SZ_HALF: wdata[8*i +: 8] = store_data[8*(i%2) +: 8];
        default: wdata[8*i +: 8] = store_data[8*i +: 8];
      endcase
    end

    case (size)
      SZ_BYTE: sign_bit = sign_ext & shifted[7];
      SZ_HALF: sign_bit = sign_ext & shifted[HALF_MSB];
      default: sign_bit = 1'b0;
    endcase

    for (int b = 0; b < DATA_W; b++) begin
      case (size)
        SZ_BYTE: load_value[b] = (b < 8)  ? shifted[b] : sign_bit;
        SZ_HALF: load_value[b] = (b < 16) ? shifted[b] : sign_bit;
        default: load_value[b] = rdata[b];
      endcase
    end
  end

endmodule

// File: rtl/mem_stage_hs.sv
// Memory stage with req/ack data port, sub-word access and MEM/WB register.
// A slow memory freezes the upstream pipeline; EX/MEM inputs stay stable
// for the whole wait, so the request is driven straight from them.
module mem_stage_hs
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEST_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic                 wb_en_in,
  input  logic                 mem_r_en_in,
  input  logic                 mem_w_en_in,
  input  logic [1:0]           size_in,
  input  logic                 signed_in,
  input  logic [DATA_W-1:0]    alu_result_in,
  input  logic [DATA_W-1:0]    store_data_in,
  input  logic [DEST_W-1:0]    dest_in,
  output logic                 freeze,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DATA_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic [DATA_W/8-1:0]  mem_be,
  input  logic                 mem_ack,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 wb_en,
  output logic                 mem_r_en,
  output logic [DATA_W-1:0]    alu_result,
  output logic [DATA_W-1:0]    mem_read_value,
  output logic [DEST_W-1:0]    dest,
  output logic                 align_err,
  output logic                 bus_err
);

  localparam int LANES     = lanes_of(DATA_W);
  localparam int LANE_BITS = lane_bits_of(DATA_W);
  localparam int CNT_W     = $clog2(TIMEOUT);

  logic [LANE_BITS-1:0] lane;
  logic                 aligned;
  logic                 is_mem;
  logic                 access;
  logic                 misaligned;
  logic                 timeout_hit;
  logic [LANES-1:0]     be_w;
  logic [DATA_W-1:0]    wdata_w;
  logic [DATA_W-1:0]    load_w;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;

  logic                 wb_en_q, wb_en_d;
  logic                 mem_r_en_q, mem_r_en_d;
  logic [DATA_W-1:0]    alu_result_q, alu_result_d;
  logic [DATA_W-1:0]    mem_read_value_q, mem_read_value_d;
  logic [DEST_W-1:0]    dest_q, dest_d;
  logic                 align_err_q, align_err_d;
  logic                 bus_err_q, bus_err_d;

  assign lane = alu_result_in[LANE_BITS-1:0];

  mem_lane_align #(
    .DATA_W    (DATA_W),
    .LANE_BITS (LANE_BITS)
  ) u_align (
    .size       (size_in),
    .sign_ext   (signed_in),
    .lane       (lane),
    .store_data (store_data_in),
    .rdata      (mem_rdata),
    .be         (be_w),
    .wdata      (wdata_w),
    .load_value (load_w)
  );

  // Access qualification, request drive and timeout detection
  always_comb begin
    case (size_in)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = ~lane[0];
      default: aligned = (lane == '0);
    endcase
    is_mem      = ex_valid & (mem_r_en_in | mem_w_en_in);
    access      = is_mem & aligned;
    misaligned  = is_mem & ~aligned;
    // wait_cnt counts request cycles already spent, so this is cycle TIMEOUT
    timeout_hit = access & ~mem_ack & (wait_cnt_q == CNT_W'(TIMEOUT - 1));
    freeze      = access & ~mem_ack & ~timeout_hit;
    mem_req     = access;
    mem_we      = access & mem_w_en_in;
    mem_be      = access ? be_w : '0;
    mem_wdata   = wdata_w;
    mem_addr    = {alu_result_in[DATA_W-1:LANE_BITS], {LANE_BITS{1'b0}}};
  end

  // Handshake FSM next state; the counter runs only while staying in WAIT
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    case (state_q)
      ST_IDLE: if (access && !mem_ack) state_d = ST_WAIT;
      ST_WAIT: if (!access || mem_ack || timeout_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_WAIT) wait_cnt_d = wait_cnt_q + CNT_W'(1);
  end

  // FSM state and wait counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // MEM/WB next value: bubble, dropped access, timed-out access or result
  always_comb begin
    wb_en_d          = 1'b0;
    mem_r_en_d       = 1'b0;
    alu_result_d     = alu_result_q;
    mem_read_value_d = mem_read_value_q;
    dest_d           = dest_q;
    align_err_d      = misaligned;
    bus_err_d        = bus_err_q | timeout_hit;
    if (!ex_valid || freeze || misaligned) begin
      // bubble: only the enables are cleared, data fields hold
    end else if (timeout_hit) begin
      mem_r_en_d       = mem_r_en_in;
      alu_result_d     = alu_result_in;
      mem_read_value_d = '0;
      dest_d           = dest_in;
    end else begin
      wb_en_d          = wb_en_in;
      mem_r_en_d       = mem_r_en_in;
      alu_result_d     = alu_result_in;
      mem_read_value_d = load_w;
      dest_d           = dest_in;
    end
  end

  // MEM/WB pipeline register and error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q          <= 1'b0;
      mem_r_en_q       <= 1'b0;
      alu_result_q     <= '0;
      mem_read_value_q <= '0;
      dest_q           <= '0;
      align_err_q      <= 1'b0;
      bus_err_q        <= 1'b0;
    end else begin
      wb_en_q          <= wb_en_d;
      mem_r_en_q       <= mem_r_en_d;
      alu_result_q     <= alu_result_d;
      mem_read_value_q <= mem_read_value_d;
      dest_q           <= dest_d;
      align_err_q      <= align_err_d;
      bus_err_q        <= bus_err_d;
    end
  end

  assign wb_en          = wb_en_q;
  assign mem_r_en       = mem_r_en_q;
  assign alu_result     = alu_result_q;
  assign mem_read_value = mem_read_value_q;
  assign dest           = dest_q;
  assign align_err      = align_err_q;
  assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs with hand-computed expected values.
module tb_mem_stage_hs;

  localparam int DATA_W  = 32;
  localparam int DEST_W  = 4;
  localparam int TIMEOUT = 16;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ex_valid, wb_en_in, mem_r_en_in, mem_w_en_in, signed_in;
  logic [1:0]        size_in;
  logic [DATA_W-1:0] alu_result_in, store_data_in;
  logic [DEST_W-1:0] dest_in;
  logic              freeze, mem_req, mem_we, mem_ack;
  logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]        mem_be;
  logic              wb_en, mem_r_en, align_err, bus_err;
  logic [DATA_W-1:0] alu_result, mem_read_value;
  logic [DEST_W-1:0] dest;

  int n_chk  = 0;
  int n_fail = 0;

  mem_stage_hs #(.DATA_W(DATA_W), .DEST_W(DEST_W), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .wb_en_in       (wb_en_in),
    .mem_r_en_in    (mem_r_en_in),
    .mem_w_en_in    (mem_w_en_in),
    .size_in        (size_in),
    .signed_in      (signed_in),
    .alu_result_in  (alu_result_in),
    .store_data_in  (store_data_in),
    .dest_in        (dest_in),
    .freeze         (freeze),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_be         (mem_be),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .wb_en          (wb_en),
    .mem_r_en       (mem_r_en),
    .alu_result     (alu_result),
    .mem_read_value (mem_read_value),
    .dest           (dest),
    .align_err      (align_err),
    .bus_err        (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wb, input logic rd, input logic wr,
                       input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [3:0] d);
    ex_valid      = v;
    wb_en_in      = wb;
    mem_r_en_in   = rd;
    mem_w_en_in   = wr;
    size_in       = sz;
    signed_in     = sg;
    alu_result_in = addr;
    store_data_in = sd;
    dest_in       = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, W, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Word load that never gets an ack; expects TIMEOUT-1 frozen cycles
  task automatic run_timeout(input string tag, input logic [31:0] addr);
    int nfrz;
    nfrz = 0;
    mem_ack = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, W, 1'b0, addr, 32'h0, 4'h6);
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!freeze) break;
      nfrz++;
      step();
    end
    chk({tag, "_freeze_cycles"}, 64'(nfrz), 64'(TIMEOUT - 1));
    chk({tag, "_req_last"}, 64'(mem_req), 64'd1);
    step();
    chk({tag, "_bus_err"}, 64'(bus_err), 64'd1);
    chk({tag, "_wb_en"}, 64'(wb_en), 64'd0);
    chk({tag, "_rvalue"}, 64'(mem_read_value), 64'd0);
    idle();
    #1;
    chk({tag, "_req_after"}, 64'(mem_req), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] val;
  } ld_vec_t;

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] wa;
  } st_vec_t;

  ld_vec_t ld_tab[5];
  st_vec_t st_tab[3];

  initial begin
    int nfrz;

    // rdata 0x80123456: lane0=56 lane1=34 lane2=12 lane3=80
    ld_tab[0] = '{H, 1'b0, 32'h102, 4'b1100, 32'h0000_8012};
    ld_tab[1] = '{H, 1'b1, 32'h102, 4'b1100, 32'hFFFF_8012};
    ld_tab[2] = '{B, 1'b0, 32'h101, 4'b0010, 32'h0000_0034};
    ld_tab[3] = '{B, 1'b1, 32'h100, 4'b0001, 32'h0000_0056};
    ld_tab[4] = '{H, 1'b1, 32'h100, 4'b0011, 32'h0000_3456};

    st_tab[0] = '{H, 32'h202, 32'h0000_1234, 4'b1100, 32'h1234_1234, 32'h200};
    st_tab[1] = '{B, 32'h201, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB, 32'h200};
    st_tab[2] = '{W, 32'h204, 32'h1122_3344, 4'b1111, 32'h1122_3344, 32'h204};

    idle();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;

    // Reset values
    #12;
    chk("rst_wb_en", 64'(wb_en), 64'd0);
    chk("rst_mem_r_en", 64'(mem_r_en), 64'd0);
    chk("rst_alu_result", 64'(alu_result), 64'd0);
    chk("rst_rvalue", 64'(mem_read_value), 64'd0);
    chk("rst_dest", 64'(dest), 64'd0);
    chk("rst_align_err", 64'(align_err), 64'd0);
    chk("rst_bus_err", 64'(bus_err), 64'd0);
    @(negedge clk) rst = 1'b1;
    step();

    // Zero-wait word load
    drive(1'b1, 1'b1, 1'b1, 1'b0, W, 1'b0, 32'h100, 32'h0, 4'h5);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ldw_freeze", 64'(freeze), 64'd0);
    chk("ldw_req", 64'(mem_req), 64'd1);
    chk("ldw_addr", 64'(mem_addr), 64'h100);
    chk("ldw_be", 64'(mem_be), 64'hF);
    chk("ldw_we", 64'(mem_we), 64'd0);
    step();
    chk("ldw_wb_en", 64'(wb_en), 64'd1);
    chk("ldw_mem_r_en", 64'(mem_r_en), 64'd1);
    chk("ldw_rvalue", 64'(mem_read_value), 64'hDEAD_BEEF);
    chk("ldw_dest", 64'(dest), 64'h5);

    // Non-memory op passes the ALU result through
    drive(1'b1, 1'b1, 1'b0, 1'b0, W, 1'b0, 32'hCAFE_F00D, 32'h0, 4'h7);
    mem_ack = 1'b0;
    #1;
    chk("alu_req", 64'(mem_req), 64'd0);
    chk("alu_freeze", 64'(freeze), 64'd0);
    step();
    chk("alu_wb_en", 64'(wb_en), 64'd1);
    chk("alu_result", 64'(alu_result), 64'hCAFE_F00D);
    chk("alu_dest", 64'(dest), 64'h7);
    chk("alu_mem_r_en", 64'(mem_r_en), 64'd0);

    // ex_valid low is a bubble that holds data fields
    idle();
    step();
    chk("bub_wb_en", 64'(wb_en), 64'd0);
    chk("bub_hold_alu", 64'(alu_result), 64'hCAFE_F00D);

    // Signed byte load, ack in the third request cycle
    drive(1'b1, 1'b1, 1'b1, 1'b0, B, 1'b1, 32'h103, 32'h0, 4'h9);
    mem_rdata = 32'h8012_3456;
    nfrz = 0;
    for (int c = 1; c <= 3; c++) begin
      mem_ack = (c == 3);
      #1;
      if (freeze) nfrz++;
      if (c == 1) begin
        chk("ldb_be", 64'(mem_be), 64'b1000);
        chk("ldb_addr", 64'(mem_addr), 64'h100);
      end
      step();
      if (c < 3) chk("ldb_bubble", 64'(wb_en), 64'd0);
    end
    chk("ldb_freeze_cycles", 64'(nfrz), 64'd2);
    chk("ldb_wb_en", 64'(wb_en), 64'd1);
    chk("ldb_rvalue", 64'(mem_read_value), 64'hFFFF_FF80);

    // Sub-word loads, zero-wait
    mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, ld_tab[i].sz, ld_tab[i].sg, ld_tab[i].addr, 32'h0, 4'h2);
      #1;
      chk("ld_be", 64'(mem_be), 64'(ld_tab[i].be));
      step();
      chk("ld_rvalue", 64'(mem_read_value), 64'(ld_tab[i].val));
    end

    // Stores, zero-wait
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, st_tab[i].sz, 1'b0, st_tab[i].addr, st_tab[i].sd, 4'h0);
      #1;
      chk("st_we", 64'(mem_we), 64'd1);
      chk("st_be", 64'(mem_be), 64'(st_tab[i].be));
      chk("st_wdata", 64'(mem_wdata), 64'(st_tab[i].wd));
      chk("st_addr", 64'(mem_addr), 64'(st_tab[i].wa));
      chk("st_freeze", 64'(freeze), 64'd0);
      step();
      chk("st_wb_en", 64'(wb_en), 64'd0);
    end
    mem_ack = 1'b0;

    // Misaligned word load is dropped with a one-cycle align_err
    drive(1'b1, 1'b1, 1'b1, 1'b0, W, 1'b0, 32'h101, 32'h0, 4'h4);
    #1;
    chk("mis_req", 64'(mem_req), 64'd0);
    chk("mis_freeze", 64'(freeze), 64'd0);
    step();
    chk("mis_align_err", 64'(align_err), 64'd1);
    chk("mis_wb_en", 64'(wb_en), 64'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, H, 1'b0, 32'h203, 32'h55, 4'h0);
    #1;
    chk("mis_st_req", 64'(mem_req), 64'd0);
    chk("mis_st_we", 64'(mem_we), 64'd0);
    step();
    chk("mis_st_align_err", 64'(align_err), 64'd1);
    idle();
    step();
    chk("mis_pulse_end", 64'(align_err), 64'd0);

    // Timeout, then a spurious ack is ignored
    run_timeout("to1", 32'h300);
    mem_ack = 1'b1;
    step();
    chk("spur_bus_err", 64'(bus_err), 64'd1);
    chk("spur_wb_en", 64'(wb_en), 64'd0);
    chk("spur_req", 64'(mem_req), 64'd0);
    chk("spur_freeze", 64'(freeze), 64'd0);
    mem_ack = 1'b0;

    // Reset while waiting
    drive(1'b1, 1'b1, 1'b0, 1'b0, W, 1'b0, 32'h55, 32'h0, 4'h3);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, W, 1'b0, 32'h400, 32'h0, 4'h8);
    step();
    step();
    #1;
    chk("rw_frozen", 64'(freeze), 64'd1);
    #1;
    rst = 1'b0;
    idle();
    #1;
    chk("rw_wb_en", 64'(wb_en), 64'd0);
    chk("rw_alu_result", 64'(alu_result), 64'd0);
    chk("rw_dest", 64'(dest), 64'd0);
    chk("rw_bus_err", 64'(bus_err), 64'd0);
    chk("rw_req", 64'(mem_req), 64'd0);
    @(negedge clk) rst = 1'b1;
    step();
    run_timeout("to2", 32'h500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_hs.md
# mem_stage_hs

Parametrised memory stage with a request/acknowledge data-memory port, sub-word access and an integrated MEM/WB pipeline register. It supersedes the single-cycle memory stage: it tolerates variable-latency memory by freezing the upstream pipeline. It performs byte/halfword/word loads and stores with lane steering and sign extension, and flags misaligned and timed-out accesses. It sits between the EX/MEM register and the WB stage.

## Interface
- DATA_W, 32: data/address width; multiple of 8, power of two
- DEST_W, 4: destination register index width
- TIMEOUT, 16: max cycles a request may wait for `mem_ack`; minimum 2
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX/MEM holds a valid instruction
- wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control from EX/MEM; rd and wr never both 1
- size_in  in  2  00 byte, 01 half, 10 word; 11 treated as word
- signed_in  in  1  sign-extend sub-word loads
- alu_result_in  in  DATA_W  address, or the result for non-memory ops
- store_data_in  in  DATA_W  store data, right-aligned
- dest_in  in  DEST_W  destination register
- freeze  out  1  stall EX/MEM and earlier stages
- mem_req, mem_we  out  1 each  memory request, write strobe
- mem_addr  out  DATA_W  word-aligned address (low log2(DATA_W/8) bits zero)
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_be  out  DATA_W/8  byte enables
- mem_ack  in  1  request completes this cycle
- mem_rdata  in  DATA_W  read data, valid with `mem_ack`
- wb_en, mem_r_en  out  1 each  registered to WB
- alu_result, mem_read_value  out  DATA_W each  registered to WB
- dest  out  DEST_W  registered to WB
- align_err  out  1  registered one-cycle pulse, misaligned access dropped
- bus_err  out  1  sticky, an access timed out

## Operation
- Access = ex_valid & (mem_r_en_in | mem_w_en_in) & aligned. Aligned: half needs addr[0]=0; word needs all low lane bits zero.
- mem_req driven combinationally while an access is pending. Address, data, enables and we are held stable through the wait because upstream is frozen.
- Byte lane l = addr low bits. Byte: be = 1<<l. Half: be = 2'b11<<l. Word: all ones. Store data replicated per size.
- Load: extract lane, zero- or sign-extend per signed_in. Word passes through unchanged.
- freeze = access pending & !mem_ack & !timeout_hit.
- FSM IDLE/WAIT. IDLE→WAIT on a pending access without ack. WAIT→IDLE on ack or timeout. wait_cnt is cleared in IDLE and increments in WAIT. timeout_hit = wait_cnt==TIMEOUT-1 & !ack.
- MEM/WB register loads every cycle:
  - while frozen: bubble (wb_en=0, mem_r_en=0; other fields hold).
  - on completion or a non-memory op: EX/MEM fields, with mem_read_value = extended load data.
  - ex_valid=0: bubble.
- Misaligned access: no request issued and no freeze. Completes in one cycle with wb_en=0 and align_err pulsed.
- Timeout: completes with wb_en=0 and mem_read_value=0, and sets bus_err.
- mem_ack while no request is pending is ignored.

## Timing
- Reset (rst=0, async): wb_en, mem_r_en, alu_result, mem_read_value, dest, align_err, bus_err = 0; state IDLE; wait_cnt=0. Combinational outputs follow the inputs.
- Zero-wait memory (ack in the request cycle): freeze never rises; result appears at the next edge, same as the single-cycle stage.
- N-cycle ack (ack in the Nth request cycle): freeze high for N-1 cycles; N-1 bubbles enter WB; result registered at the edge ending cycle N.
- Timeout: freeze high for TIMEOUT-1 cycles, drops in cycle TIMEOUT; mem_req low the following cycle.
- Reset mid-wait: mem_req drops immediately once the inputs return to reset values; the FSM is in IDLE. The memory must discard the outstanding request.
- bus_err is cleared only by reset.

## Structure
- Package mem_pkg: size encoding constants, state enum, lane-count/lane-bit localparams derived from DATA_W.
- Sub-module mem_lane_align (combinational): byte enables, store replication, load extract/extend.
- FSM, counter and MEM/WB register live in the top module.

## Test plan
- Word load at 0x100, ack in cycle 1, rdata 0xDEADBEEF → no freeze; next edge wb_en=1, mem_read_value=0xDEADBEEF.
- Signed byte load at 0x103, ack after 3 cycles, rdata 0x80xxxxxx → be=4'b1000; freeze high 2 cycles; 2 bubbles; mem_read_value=0xFFFFFF80.
- Half store 0x1234 at 0x202, ack immediate → mem_be=4'b1100, mem_wdata=0x12341234, mem_we=1.
- Word load at 0x101 → mem_req stays 0, align_err=1 for one cycle, wb_en=0.
- No ack, TIMEOUT=16 → freeze high 15 cycles; bus_err=1 and stays 1; a later spurious ack is ignored.
- Assert rst while in WAIT → all registered outputs 0 asynchronously; the next access starts from IDLE with wait_cnt=0.
